// File: rtl/delay_monitor.sv
// delay_monitor: checks the interval between sig pulses against N+1 +/- TOL cycles.
// Optional macro DELAY_MON_STICKY_EN makes err latch on the first violation until rst.
`default_nettype none

module delay_monitor #(
  parameter int N        = 750,
  parameter int CBITS    = 10,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 2,
  parameter int ECBITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  output logic              lock,
  output logic              early,
  output logic              late,
  output logic              err,
  output logic [CBITS-1:0]  period,
  output logic [ECBITS-1:0] err_cnt
);

  localparam int GBITS = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CBITS-1:0] LO       = CBITS'(N + 1 - TOL);
  localparam logic [CBITS-1:0] HI       = CBITS'(N + 1 + TOL);
  localparam logic [GBITS-1:0] GOOD_MAX = GBITS'(LOCK_CNT);

  localparam logic [1:0] SEEK = 2'd0;
  localparam logic [1:0] MEAS = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  logic [1:0]       state;
  logic [CBITS-1:0] cnt;
  logic [GBITS-1:0] good;
  logic [GBITS-1:0] good_next;
  logic             armed;
  logic             ev_early;
  logic             ev_late;
  logic             ev_any;

  // A pulse seen in SEEK only arms the measurement, so it can never be a violation.
  assign armed     = (state != SEEK);
  assign ev_early  = armed && sig && (cnt < LO);
  assign ev_late   = armed && !sig && (cnt == HI);
  assign ev_any    = ev_early || ev_late;
  assign good_next = (good == GOOD_MAX) ? good : good + GBITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEEK;
      cnt     <= '0;
      good    <= '0;
      lock    <= 1'b0;
      early   <= 1'b0;
      late    <= 1'b0;
      period  <= '0;
    end else begin
      early <= ev_early;
      late  <= ev_late;
      if (!armed) begin
        if (sig) begin
          state <= MEAS;
          cnt   <= CBITS'(1);
          good  <= '0;
        end
      end else if (sig) begin
        // cnt == HI with sig=1 lands here and counts as a good interval.
        period <= cnt;
        cnt    <= CBITS'(1);
        if (ev_early) begin
          good  <= '0;
          state <= MEAS;
          lock  <= 1'b0;
        end else begin
          good <= good_next;
          if (good_next == GOOD_MAX) begin
            state <= LOCK;
            lock  <= 1'b1;
          end else begin
            state <= MEAS;
          end
        end
      end else if (ev_late) begin
        good  <= '0;
        state <= SEEK;
        lock  <= 1'b0;
      end else begin
        cnt <= cnt + CBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (ev_any && (err_cnt != {ECBITS{1'b1}})) begin
      err_cnt <= err_cnt + ECBITS'(1);
    end
  end

`ifdef DELAY_MON_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ev_any) begin
      err <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= ev_any;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor: defaults, TOL=2 and ECBITS=2 instances.
`default_nettype none

module tb_delay_monitor;

`ifdef DELAY_MON_STICKY_EN
  localparam int STICKY = 1;
`else
  localparam int STICKY = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sig0, sig1, sig2;
  always #5 clk = ~clk;

  logic       lock0, early0, late0, err0;
  logic [9:0] period0;
  logic [7:0] errc0;
  logic       lock1, early1, late1, err1;
  logic [9:0] period1;
  logic [7:0] errc1;
  logic       lock2, early2, late2, err2;
  logic [9:0] period2;
  logic [1:0] errc2;

  delay_monitor dut0 (
    .clk(clk), .rst(rst), .sig(sig0), .lock(lock0), .early(early0), .late(late0),
    .err(err0), .period(period0), .err_cnt(errc0)
  );

  delay_monitor #(.N(750), .CBITS(10), .TOL(2)) dut1 (
    .clk(clk), .rst(rst), .sig(sig1), .lock(lock1), .early(early1), .late(late1),
    .err(err1), .period(period1), .err_cnt(errc1)
  );

  delay_monitor #(.N(9), .CBITS(10), .TOL(0), .ECBITS(2)) dut2 (
    .clk(clk), .rst(rst), .sig(sig2), .lock(lock2), .early(early2), .late(late2),
    .err(err2), .period(period2), .err_cnt(errc2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle pulse; returns just after the edge that sampled it.
  task automatic pulse(input int which);
    case (which)
      0: sig0 = 1'b1;
      1: sig1 = 1'b1;
      default: sig2 = 1'b1;
    endcase
    tick();
    sig0 = 1'b0;
    sig1 = 1'b0;
    sig2 = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    sig0 = 1'b0;
    sig1 = 1'b0;
    sig2 = 1'b0;
    idle(2);
    chk("rst_lock", 32'(lock0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_period", 32'(period0), 0);
    chk("rst_errcnt", 32'(errc0), 0);
    rst = 1'b0;
    idle(3);

    // Nominal stream, 751-cycle intervals
    pulse(0);
    chk("arm_early", 32'(early0), 0);
    idle(750); pulse(0);
    chk("p2_lock", 32'(lock0), 0);
    chk("p2_period", 32'(period0), 751);
    idle(750); pulse(0);
    chk("p3_lock", 32'(lock0), 1);
    chk("p3_period", 32'(period0), 751);
    chk("p3_err", 32'(err0), 0);
    chk("p3_late", 32'(late0), 0);
    chk("p3_errcnt", 32'(errc0), 0);

    // Early interval of 700 while locked
    idle(699); pulse(0);
    chk("early_flag", 32'(early0), 1);
    chk("early_err", 32'(err0), 1);
    chk("early_lock", 32'(lock0), 0);
    chk("early_period", 32'(period0), 700);
    chk("early_errcnt", 32'(errc0), 1);
    tick();
    chk("early_width", 32'(early0), 0);
    chk("early_err_after", 32'(err0), STICKY);
    idle(749); pulse(0);
    chk("relock1_lock", 32'(lock0), 0);
    idle(750); pulse(0);
    chk("relock2_lock", 32'(lock0), 1);
    chk("relock2_period", 32'(period0), 751);

    // Stream stops while locked
    idle(750);
    chk("prelate_late", 32'(late0), 0);
    chk("prelate_lock", 32'(lock0), 1);
    tick();
    chk("late_flag", 32'(late0), 1);
    chk("late_lock", 32'(lock0), 0);
    chk("late_errcnt", 32'(errc0), 2);
    chk("late_period", 32'(period0), 751);
    tick();
    chk("late_width", 32'(late0), 0);
    idle(100); pulse(0);
    chk("rearm_early", 32'(early0), 0);
    chk("rearm_errcnt", 32'(errc0), 2);
    chk("rearm_err", 32'(err0), STICKY);
    idle(750); pulse(0);
    idle(750); pulse(0);
    chk("relock3_lock", 32'(lock0), 1);

    // Asynchronous reset between edges
    idle(100);
    chk("pre_arst_errcnt", 32'(errc0), 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_lock", 32'(lock0), 0);
    chk("arst_err", 32'(err0), 0);
    chk("arst_errcnt", 32'(errc0), 0);
    chk("arst_period", 32'(period0), 0);
    #1 rst = 1'b0;
    tick();
    pulse(0);
    chk("post_arst_early", 32'(early0), 0);
    chk("post_arst_errcnt", 32'(errc0), 0);

    // TOL=2: window 749..753
    pulse(1);
    idle(748); pulse(1);
    chk("tol_749_early", 32'(early1), 0);
    chk("tol_749_period", 32'(period1), 749);
    idle(752); pulse(1);
    chk("tol_753_early", 32'(early1), 0);
    chk("tol_753_lock", 32'(lock1), 1);
    chk("tol_753_period", 32'(period1), 753);
    idle(747); pulse(1);
    chk("tol_748_early", 32'(early1), 1);
    chk("tol_748_lock", 32'(lock1), 0);
    chk("tol_748_errcnt", 32'(errc1), 1);
    idle(752);
    chk("tol_prelate", 32'(late1), 0);
    tick();
    chk("tol_late", 32'(late1), 1);
    chk("tol_late_errcnt", 32'(errc1), 2);

    // ECBITS=2 saturation over five early events
    pulse(2);
    for (int k = 1; k <= 5; k++) begin
      idle(4); pulse(2);
      chk("sat_early", 32'(early2), 1);
      chk("sat_err", 32'(err2), 1);
      chk("sat_errcnt", 32'(errc2), (k < 3) ? k : 3);
      tick();
      chk("sat_err_after", 32'(err2), STICKY);
    end
    chk("sat_final", 32'(errc2), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delay_monitor.md
# delay_monitor

- Receive-side checker for the periodic `sig` pulse produced by the team's delay/pulse generator.
- Measures the interval between successive `sig` pulses and checks it against the nominal period N+1 cycles, within ±TOL cycles.
- Reports lock, early and late violations, the last measured interval, and a saturating error count.
- Sits next to the generator in formal and simulation benches; its outputs are the observables for liveness and safety properties.

## Interface
- N, 750: generator threshold; nominal interval is N+1 cycles.
- CBITS, 10: interval counter width; N+1+TOL < 2^CBITS is required.
- TOL, 0: accepted deviation in cycles; TOL < N+1 is required.
- LOCK_CNT, 2: consecutive in-window intervals needed to assert lock.
- ECBITS, 8: width of the error counter.
- clk, input, 1: single clock, all state on posedge.
- rst, input, 1: asynchronous, active-high reset.
- sig, input, 1: pulse stream under check, sampled on posedge clk.
- lock, output, 1: stream is in lock.
- early, output, 1: one-cycle pulse; interval was shorter than the window.
- late, output, 1: one-cycle pulse; no pulse arrived by the end of the window.
- err, output, 1: early OR late (see Configuration).
- period, output, CBITS: last measured interval.
- err_cnt, output, ECBITS: saturating count of violations.

## Operation
- Reset: all outputs 0. State is SEEK, cnt=0, good=0. Reset applies immediately, without waiting for a clock edge.
- cnt is loaded with 1 on the edge that samples sig=1, then increments by 1 per cycle. A pulse therefore sees cnt = I, the interval since the previous pulse.
- Window: lo = N+1−TOL, hi = N+1+TOL. An interval is good if lo ≤ I ≤ hi.
- SEEK: cnt is frozen.
  - sig=1 → MEAS, cnt=1, good=0.
  - A pulse in SEEK is never an error.
- MEAS and LOCK, on sig=1:
  - Updates `period` to I, restarts cnt=1.
  - I < lo: early, good=0, state MEAS, lock=0.
  - I good: good increments, saturating at LOCK_CNT. When good reaches LOCK_CNT, state is LOCK and lock=1.
- MEAS and LOCK, with sig=0 and cnt==hi:
  - late, good=0, state SEEK, lock=0.
  - `period` is unchanged.
- sig=1 with cnt==hi in the same cycle counts as a good interval, not late.
- sig held high for consecutive cycles: each high cycle is a separate pulse. I=1 is early whenever lo>1.
- err_cnt increments by 1 on each early or late event and holds at all-ones. Only rst clears it.

## Timing
- All outputs are registered.
- early, late and err assert in the cycle after the detecting edge, for exactly one cycle (unless sticky).
- lock rises in the cycle after the LOCK_CNT-th good pulse is sampled.
- lock falls in the cycle err asserts.
- period and err_cnt update in the same cycle as the corresponding pulse or error output.
- First lock from reset with nominal stream: pulse 1 arms, pulses 2..LOCK_CNT+1 qualify. lock=1 one cycle after pulse LOCK_CNT+1.
- Async rst mid-interval: outputs drop to 0 at once. After release, the first pulse re-arms with no error.

## Configuration
- DELAY_MON_STICKY_EN defined: err latches to 1 on the first violation and holds until rst. early and late remain one-cycle pulses.
- DELAY_MON_STICKY_EN undefined: err is the one-cycle OR of early and late.
- lock, period and err_cnt behave identically in both builds.

## Test plan
- Nominal, defaults: pulses every 751 cycles.
  - lock=1 one cycle after the 3rd pulse.
  - period=751.
  - err, early, late, err_cnt stay 0.
- Early: while locked, pulse at interval 700.
  - Next cycle: early=1, err=1, lock=0, period=700, err_cnt=1.
  - Two further 751-cycle intervals restore lock=1.
- Late: while locked, pulses stop.
  - cnt reaches 751 with sig=0; next cycle late=1, lock=0, err_cnt increments.
  - The next pulse produces no error.
- TOL=2:
  - Intervals 749 and 753 are good.
  - 748 → early.
  - No pulse by cnt=753 → late.
- Async rst pulse between clock edges mid-interval: lock, err and err_cnt are 0 immediately, before the next posedge.
- ECBITS=2, five early events: err_cnt ends at 3.
  - With DELAY_MON_STICKY_EN: err stays 1 from the first event until rst.
  - Without it: err pulses five times.
